// File: rtl/prog_loader.sv
// prog_loader: buffers a framed program image from a valid/ready byte stream and replays it as one burst.
// Define PROG_LOADER_CHECKSUM_EN to check the trailer as a two's-complement checksum of the image.
module prog_loader #(
  parameter int PROG_BYTES = 28,
  parameter int IDX_WIDTH  = $clog2(PROG_BYTES + 1)
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       prog_enable,
  output logic [7:0] prog_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] error
);
  typedef enum logic [2:0] {IDLE, FILL, TRAILER, DRAIN, BURST, DONE} state_t;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(PROG_BYTES - 1);
  state_t state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d, waddr;
  logic [1:0] error_q, error_d;
  logic [7:0] mem_q [PROG_BYTES];
  logic s_ready_q, busy_q, done_q, prog_enable_q;
  logic [7:0] prog_data_q;
  logic xfer, wr_en, ok;
  assign xfer  = s_valid && s_ready_q;
  assign waddr = state_q == IDLE ? '0 : idx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  assign ok = 8'(sum_q + s_data) == 8'h00;
`else
  assign ok = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    error_d = error_q;
    wr_en   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: if (xfer) begin
        if (s_last) error_d = 2'b01;
        else begin
          wr_en   = 1'b1;
          idx_d   = IDX_WIDTH'(1);
          error_d = 2'b00;
          state_d = PROG_BYTES == 1 ? TRAILER : FILL;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = s_data;
`endif
        end
      end
      FILL: if (xfer) begin
        if (s_last) begin
          error_d = 2'b01;
          state_d = IDLE;
        end else begin
          wr_en   = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = idx_q == LAST ? TRAILER : FILL;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + s_data;
`endif
        end
      end
      TRAILER: if (xfer) begin
        idx_d   = '0;
        error_d = !s_last ? 2'b10 : ok ? error_q : 2'b11;
        state_d = !s_last ? DRAIN : ok ? BURST : IDLE;
      end
      DRAIN: if (xfer && s_last) state_d = IDLE;
      BURST: begin
        idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
        state_d = idx_q == LAST ? DONE : BURST;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs lag the burst state by one cycle, so the done pulse lands while state is already IDLE;
  // s_ready and busy are held off for that cycle to keep the host out until the pulse is gone.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      error_q       <= 2'b00;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      prog_enable_q <= 1'b0;
      prog_data_q   <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      error_q       <= error_d;
      s_ready_q     <= state_d inside {IDLE, FILL, TRAILER, DRAIN} && state_q != DONE;
      busy_q        <= state_d != IDLE || state_q == DONE;
      done_q        <= state_q == DONE;
      prog_enable_q <= state_q == BURST;
      prog_data_q   <= state_q == BURST ? mem_q[idx_q] : 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end
  always_ff @(posedge clock) if (wr_en) mem_q[waddr] <= s_data;
  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign prog_enable = prog_enable_q;
  assign prog_data   = prog_data_q;
  assign error       = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench with a byte scoreboard for the replay burst of prog_loader.
module tb_prog_loader;
  logic clock, rst, s_valid, s_ready, s_last, prog_enable, busy, done;
  logic [7:0] s_data, prog_data;
  logic [1:0] error;
  logic [7:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int n, len;

  prog_loader dut (
    .clock(clock), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .prog_enable(prog_enable), .prog_data(prog_data), .busy(busy),
    .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int w = 0;
    s_valid = 1'b1; s_data = b; s_last = l;
    while (!s_ready && w < 100) begin @(negedge clock); w++; end
    if (w >= 100) check("send_ready_timeout", s_ready, 1);
    @(negedge clock);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] first, input int count, input bit last_on_final,
                            input bit push, input int gap_max);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clock);
      send(first + 8'(i), last_on_final && i == count - 1);
      if (push) exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic idle_window(input string tag, input int cycles);
    int en = 0;
    repeat (cycles) begin @(negedge clock); if (prog_enable) en++; end
    check(tag, en, 0);
  endtask

  task automatic wait_burst(input string tag);
    int w = 0, blen = 0, rdy = 0, gaps = 0, first = 0;
    logic prev = 1'b0;
    check({tag, "_lat0"}, prog_enable, 0);
    while (!done && w < 100) begin
      @(negedge clock); w++;
      if (s_ready) rdy++;
      if (prog_enable) begin
        blen++;
        if (first == 0) first = w;
        if (exp_q.size() != 0) check({tag, "_data"}, prog_data, exp_q.pop_front());
        else check({tag, "_overrun"}, blen, 28);
      end
      if (prev && !prog_enable && !done) gaps++;
      prev = prog_enable;
    end
    s_valid = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_len"}, blen, 28);
    check({tag, "_first"}, first, 1);
    check({tag, "_gaps"}, gaps, 0);
    check({tag, "_ready_in_burst"}, rdy, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_leftover"}, exp_q.size(), 0);
    @(negedge clock);
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_ready_after"}, s_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    @(negedge clock);
    check("rst_ready", s_ready, 0);
    check("rst_enable", prog_enable, 0);
    check("rst_data", prog_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clock); rst = 1'b0;
    @(negedge clock);
    check("idle_ready", s_ready, 1);
    check("idle_busy", busy, 0);

    // good frame 0x01..0x1C, trailer 0x6A
    send(8'h01, 1'b0); exp_q.push_back(8'h01);
    check("fill_busy", busy, 1);
    send_bytes(8'h02, 27, 1'b0, 1'b1, 0);
    send(8'h6A, 1'b1);
    wait_burst("good");

    // bad checksum trailer 0x6B
    send_bytes(8'h01, 28, 1'b0, `ifdef PROG_LOADER_CHECKSUM_EN 1'b0 `else 1'b1 `endif, 0);
    send(8'h6B, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    idle_window("badsum_no_burst", 40);
    check("badsum_error", error, 3);
    check("badsum_ready", s_ready, 1);
    check("badsum_busy", busy, 0);
`else
    wait_burst("badsum_ignored");
`endif

    // short frame: 10 bytes, last flagged
    send_bytes(8'h01, 10, 1'b1, 1'b0, 0);
    check("short_error", error, 1);
    check("short_busy", busy, 0);
    idle_window("short_no_burst", 5);
    send(8'h01, 1'b0); exp_q.push_back(8'h01);
    check("short_cleared", error, 0);
    send_bytes(8'h02, 27, 1'b0, 1'b1, 0);
    send(8'h6A, 1'b1);
    wait_burst("after_short");

    // long frame: trailer without s_last, then 3 extra bytes
    send_bytes(8'h01, 28, 1'b0, 1'b0, 0);
    check("long_trailer_ready", s_ready, 1);
    send(8'h6A, 1'b0);
    check("long_error", error, 2);
    check("long_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      check("drain_ready", s_ready, 1);
      send(8'hA0 + 8'(i), i == 2);
    end
    check("long_error_hold", error, 2);
    check("long_idle", busy, 0);
    idle_window("long_no_burst", 5);

    // backpressure during fill, s_valid held high through burst and done
    send_bytes(8'h01, 28, 1'b0, 1'b1, 3);
    send(8'h6A, 1'b1);
    s_valid = 1'b1; s_data = 8'h55;
    wait_burst("backpressure");

    // async reset mid-burst
    send_bytes(8'h01, 28, 1'b0, 1'b1, 0);
    send(8'h6A, 1'b1);
    n = 0; len = 0;
    while (len < 5 && n < 100) begin
      @(negedge clock); n++;
      if (prog_enable) begin
        len++;
        check("prerst_data", prog_data, exp_q.pop_front());
      end
    end
    check("prerst_len", len, 5);
    #2 rst = 1'b1;
    #1;
    check("arst_enable", prog_enable, 0);
    check("arst_data", prog_data, 0);
    check("arst_ready", s_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_error", error, 0);
    exp_q.delete();
    @(negedge clock); rst = 1'b0;
    @(negedge clock);
    check("post_rst_ready", s_ready, 1);
    send_bytes(8'h01, 28, 1'b0, 1'b1, 1);
    send(8'h6A, 1'b1);
    wait_burst("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
